stream_src_ctrl: RTL and testbench
==================================

Name: stream_src_ctrl

Overview:
- Parametrised N-channel successor to the two-source (fibonacci/timer) session controller.
- Detects rising edges on per-channel start requests and a shared stop, and enables exactly one producer at a time toward the CDC buffer wrapper.
- Pauses the active producer on buffer backpressure and drains the buffer before returning to idle.
- New behaviour: lowest-index arbitration of simultaneous starts, on-the-fly channel switching through a drain, drain timeout with a sticky error flag, and a saturating stall counter.

Parameters:
- N_CH, 4, number of producer channels (2..8).
- SEL_W, 2, width of the channel index; must equal ceil(log2(N_CH)).
- SWITCH_EN, 1, 1 = a start edge on another channel during RUN or WAIT triggers a switch; 0 = ignore it.
- DRAIN_TO, 1024, maximum cycles spent in DRAIN; 0 disables the timeout.
- STALL_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  N_CH  raw level start requests, one per channel.
- stop  in  1  raw level stop request.
- buffer_full  in  1  buffer full flag, already synchronised to clk.
- buffer_empty  in  1  buffer empty flag, already synchronised to clk.
- data_valid  in  1  downstream output valid.
- en  out  N_CH  one-hot producer enable.
- sel  out  SEL_W  index of the active or last channel (data-mux select).
- state_oh  out  4  one-hot state for LEDs: bit0 IDLE, bit1 RUN, bit2 WAIT, bit3 DRAIN.
- busy  out  1  high when the state is not IDLE.
- drain_err  out  1  sticky drain-timeout flag.
- stall_cnt  out  STALL_W  cycles spent in WAIT during the current session.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: state=IDLE, en=0, sel=0, drain_err=0, stall_cnt=0.
  - Internal: pending-valid=0, drain counter=0.
  - Edge-detector history registers = 0, so an input already high at reset release yields an edge on the first clock.
- Edge detection: edge = din & ~prev, where prev is the previous clk sample. One detector per start bit and one for stop.
- Arbitration: when several start edges occur in the same cycle, the lowest index wins.
- en is a combinational decode of the registered state: en = onehot(sel) only in RUN.
  - Latency: a start edge sampled at edge t gives en high from edge t onward (one clk).
- IDLE:
  - Any start edge -> RUN, sel <= winning index, stall_cnt <= 0.
  - A stop edge in IDLE is ignored.
- RUN, priority order:
  1. Stop edge -> DRAIN, pending cleared.
  2. SWITCH_EN and a start edge on a channel != sel -> DRAIN, pending <= lowest such index. This has priority over buffer_full.
  3. buffer_full -> WAIT.
  - A start edge on the current channel is ignored.
- WAIT:
  - Same stop and switch rules as RUN.
  - Otherwise ~buffer_full -> RUN.
  - stall_cnt increments once per WAIT cycle and saturates at all-ones.
- DRAIN:
  - en=0. The drain counter increments every cycle and is cleared on DRAIN entry.
  - buffer_empty & ~data_valid -> if pending valid: RUN, sel <= pending, pending cleared, stall_cnt held; else IDLE.
  - DRAIN_TO!=0 and counter == DRAIN_TO-1 without the drain condition -> IDLE, drain_err <= 1, pending cleared.
  - If the drain condition and the timeout coincide, drain completion wins and no error is raised.
  - Start edges are ignored. A stop edge clears pending, so the block ends in IDLE.
- drain_err clears only on reset.
- sel holds its value in IDLE (last channel).
- Backpressure contract: en drops one cycle after buffer_full is sampled. The wrapper must absorb one extra write (almost-full margin of 1).
- The state encoding is free; state_oh must be exactly one-hot at all times after reset.

Test Plan:
- Basic session: reset, start[2] rises -> en=4'b0100 from the next cycle, sel=2. Stop pulse -> DRAIN. With buffer_empty=1 and data_valid=0 -> IDLE one cycle later, state_oh=0001.
- Simultaneous starts: start[3] and start[1] rise in the same cycle -> sel=1, en=4'b0010. A later start[1] edge alone in RUN -> no change.
- Backpressure: in RUN, hold buffer_full for 5 cycles -> en=0 one cycle after the rise, state WAIT, stall_cnt=5. Release buffer_full -> RUN, en restored.
- Switch (SWITCH_EN=1): RUN on ch0, start[2] edge -> DRAIN. Hold buffer_empty=0 for 3 cycles, then 1 -> RUN with sel=2, en=4'b0100, never passing through IDLE. With SWITCH_EN=0 -> stays on ch0.
- Timeout (DRAIN_TO=8): stop with buffer_empty=0 held -> IDLE exactly 8 cycles after DRAIN entry, drain_err=1. drain_err stays 1 through a new session and clears only on rst=0.
- Async reset mid-WAIT with stall_cnt=12: pulse rst low between clock edges -> en=0, state_oh=0001, stall_cnt=0 immediately. Start held high across reset release -> RUN on the first clk.

Source files
------------

// File: rtl/stream_src_ctrl.sv
// N-channel session controller: edge-triggered start/stop, one producer enabled at a time; en follows state in the same cycle.
// Backpressure: buffer_full pauses the producer one cycle after it is sampled; the buffer must be drained before idling or switching.
module stream_src_ctrl #(
    parameter int N_CH      = 4,
    parameter int SEL_W     = 2,
    parameter int SWITCH_EN = 1,
    parameter int DRAIN_TO  = 1024,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    start,
    input  logic               stop,
    input  logic               buffer_full,
    input  logic               buffer_empty,
    input  logic               data_valid,
    output logic [N_CH-1:0]    en,
    output logic [SEL_W-1:0]   sel,
    output logic [3:0]         state_oh,
    output logic               busy,
    output logic               drain_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int DCNT_W = (DRAIN_TO > 2) ? $clog2(DRAIN_TO) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic               pend_vld_q, pend_vld_d;
    logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic               drain_err_q, drain_err_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [N_CH-1:0]    start_prev_q;
    logic               stop_prev_q;

    logic [N_CH-1:0]    start_edge, sw_edge, cur_oh;
    logic               stop_edge, drain_done, drain_timeout;
    logic [SEL_W-1:0]   start_idx, sw_idx;

    always_comb begin
        start_edge    = start & ~start_prev_q;
        stop_edge     = stop & ~stop_prev_q;
        cur_oh        = N_CH'(1) << sel_q;
        sw_edge       = (SWITCH_EN != 0) ? (start_edge & ~cur_oh) : '0;
        drain_done    = buffer_empty & ~data_valid;
        drain_timeout = (DRAIN_TO != 0) && (drain_cnt_q == DCNT_W'(DRAIN_TO - 1));
        // Scan downward so the lowest set index is the last one written.
        start_idx = '0;
        sw_idx    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (start_edge[i]) start_idx = SEL_W'(i);
            if (sw_edge[i])    sw_idx    = SEL_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pend_sel_d  = pend_sel_q;
        pend_vld_d  = pend_vld_q;
        drain_err_d = drain_err_q;
        drain_cnt_d = (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_WAIT && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (|start_edge) begin
                    state_d     = ST_RUN;
                    sel_d       = start_idx;
                    stall_cnt_d = '0;
                end
            end
            ST_RUN, ST_WAIT: begin
                if (stop_edge) begin
                    state_d    = ST_DRAIN;
                    pend_vld_d = 1'b0;
                end else if (|sw_edge) begin
                    state_d    = ST_DRAIN;
                    pend_vld_d = 1'b1;
                    pend_sel_d = sw_idx;
                end else if (state_q == ST_RUN) begin
                    if (buffer_full) state_d = ST_WAIT;
                end else if (!buffer_full) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A stop during drain cancels any queued switch.
                pend_vld_d = pend_vld_q & ~stop_edge;
                if (drain_done) begin
                    if (pend_vld_d) begin
                        state_d = ST_RUN;
                        sel_d   = pend_sel_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    pend_vld_d = 1'b0;
                end else if (drain_timeout) begin
                    state_d     = ST_IDLE;
                    drain_err_d = 1'b1;
                    pend_vld_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            pend_sel_q   <= '0;
            pend_vld_q   <= 1'b0;
            drain_cnt_q  <= '0;
            drain_err_q  <= 1'b0;
            stall_cnt_q  <= '0;
            start_prev_q <= '0;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pend_sel_q   <= pend_sel_d;
            pend_vld_q   <= pend_vld_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_err_q  <= drain_err_d;
            stall_cnt_q  <= stall_cnt_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
        end
    end

    always_comb begin
        state_oh = 4'b0001;
        case (state_q)
            ST_IDLE:  state_oh = 4'b0001;
            ST_RUN:   state_oh = 4'b0010;
            ST_WAIT:  state_oh = 4'b0100;
            ST_DRAIN: state_oh = 4'b1000;
            default:  state_oh = 4'b0001;
        endcase
    end

    assign en        = (state_q == ST_RUN) ? cur_oh : '0;
    assign sel       = sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign drain_err = drain_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stream_src_ctrl.sv
// Directed bench for stream_src_ctrl: main instance with switching and an 8-cycle drain timeout,
// second instance with switching disabled sharing the same stimulus.
module tb_stream_src_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic        stop, buffer_full, buffer_empty, data_valid;
    logic [3:0]  en, en_ns;
    logic [1:0]  sel, sel_ns;
    logic [3:0]  state_oh, state_oh_ns;
    logic        busy, busy_ns, drain_err, drain_err_ns;
    logic [15:0] stall_cnt, stall_cnt_ns;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_src_ctrl #(.N_CH(4), .SEL_W(2), .SWITCH_EN(1), .DRAIN_TO(8), .STALL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .buffer_full(buffer_full),
        .buffer_empty(buffer_empty), .data_valid(data_valid), .en(en), .sel(sel),
        .state_oh(state_oh), .busy(busy), .drain_err(drain_err), .stall_cnt(stall_cnt)
    );

    stream_src_ctrl #(.N_CH(4), .SEL_W(2), .SWITCH_EN(0), .DRAIN_TO(1024), .STALL_W(16)) dut_ns (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .buffer_full(buffer_full),
        .buffer_empty(buffer_empty), .data_valid(data_valid), .en(en_ns), .sel(sel_ns),
        .state_oh(state_oh_ns), .busy(busy_ns), .drain_err(drain_err_ns), .stall_cnt(stall_cnt_ns)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_session();
        buffer_full  = 1'b0;
        buffer_empty = 1'b1;
        data_valid   = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = '0; stop = 0; buffer_full = 0; buffer_empty = 1; data_valid = 0;
        #2;
        checks++; if (state_oh !== 4'b0001) begin errors++; $display("FAIL reset_state: got %b expected %b", state_oh, 4'b0001); end
        checks++; if (en !== 4'b0000) begin errors++; $display("FAIL reset_en: got %b expected %b", en, 4'b0000); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0 || drain_err !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_misc: busy=%b err=%b stall=%0d expected 0 0 0", busy, drain_err, stall_cnt); end
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (state_oh !== 4'b0001) begin errors++; $display("FAIL reset_release_idle: got %b expected %b", state_oh, 4'b0001); end
    endtask

    task automatic test_basic();
        start = 4'b0100;
        tick();
        checks++; if (en !== 4'b0100) begin errors++; $display("FAIL basic_en: got %b expected %b", en, 4'b0100); end
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL basic_sel: got %0d expected 2", sel); end
        checks++; if (state_oh !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL basic_run: got %b busy %b expected 0010 busy 1", state_oh, busy); end
        start = '0;
        tick();
        stop = 1'b1; data_valid = 1'b1;
        tick();
        checks++; if (state_oh !== 4'b1000) begin errors++; $display("FAIL basic_drain: got %b expected %b", state_oh, 4'b1000); end
        checks++; if (en !== 4'b0000) begin errors++; $display("FAIL basic_drain_en: got %b expected %b", en, 4'b0000); end
        stop = 1'b0;
        tick();
        checks++; if (state_oh !== 4'b1000) begin errors++; $display("FAIL basic_drain_valid_hold: got %b expected %b", state_oh, 4'b1000); end
        data_valid = 1'b0;
        tick();
        checks++; if (state_oh !== 4'b0001) begin errors++; $display("FAIL basic_idle: got %b expected %b", state_oh, 4'b0001); end
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL basic_sel_hold: got %0d expected 2", sel); end
    endtask

    task automatic test_simultaneous();
        start = 4'b1010;
        tick();
        checks++; if (sel !== 2'd1) begin errors++; $display("FAIL simul_sel: got %0d expected 1", sel); end
        checks++; if (en !== 4'b0010) begin errors++; $display("FAIL simul_en: got %b expected %b", en, 4'b0010); end
        start = '0;
        tick();
        start = 4'b0010;
        tick();
        checks++; if (en !== 4'b0010 || state_oh !== 4'b0010) begin
            errors++; $display("FAIL simul_same_ch: en %b state %b expected 0010 0010", en, state_oh); end
        start = '0;
        end_session();
    endtask

    task automatic test_backpressure();
        start = 4'b0001;
        tick();
        start = '0;
        buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                checks++; if (en !== 4'b0000) begin errors++; $display("FAIL bp_en_drop: got %b expected %b", en, 4'b0000); end
                checks++; if (state_oh !== 4'b0100) begin errors++; $display("FAIL bp_wait: got %b expected %b", state_oh, 4'b0100); end
            end
        end
        buffer_full = 1'b0;
        tick();
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 5", stall_cnt); end
        checks++; if (en !== 4'b0001 || state_oh !== 4'b0010) begin
            errors++; $display("FAIL bp_resume: en %b state %b expected 0001 0010", en, state_oh); end
        end_session();
    endtask

    task automatic test_switch();
        start = 4'b0001;
        tick();
        start = '0;
        tick();
        buffer_empty = 1'b0;
        start = 4'b0100;
        tick();
        checks++; if (state_oh !== 4'b1000) begin errors++; $display("FAIL sw_drain: got %b expected %b", state_oh, 4'b1000); end
        checks++; if (en_ns !== 4'b0001 || state_oh_ns !== 4'b0010) begin
            errors++; $display("FAIL sw_disabled_hold: en %b state %b expected 0001 0010", en_ns, state_oh_ns); end
        start = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (state_oh !== 4'b1000) begin errors++; $display("FAIL sw_drain_hold%0d: got %b expected %b", i, state_oh, 4'b1000); end
        end
        buffer_empty = 1'b1;
        tick();
        checks++; if (sel !== 2'd2 || en !== 4'b0100 || state_oh !== 4'b0010) begin
            errors++; $display("FAIL sw_run_new: sel %0d en %b state %b expected 2 0100 0010", sel, en, state_oh); end
        checks++; if (en_ns !== 4'b0001) begin errors++; $display("FAIL sw_disabled_en: got %b expected %b", en_ns, 4'b0001); end
        end_session();
    endtask

    task automatic test_timeout();
        start = 4'b0001;
        tick();
        start = '0;
        buffer_empty = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (state_oh !== 4'b1000 || drain_err !== 1'b0) begin
            errors++; $display("FAIL to_before: state %b err %b expected 1000 0", state_oh, drain_err); end
        tick();
        checks++; if (state_oh !== 4'b0001) begin errors++; $display("FAIL to_idle: got %b expected %b", state_oh, 4'b0001); end
        checks++; if (drain_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", drain_err); end
        buffer_empty = 1'b1;
        start = 4'b0010;
        tick();
        start = '0;
        checks++; if (en !== 4'b0010 || drain_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky_run: en %b err %b expected 0010 1", en, drain_err); end
        end_session();
        checks++; if (drain_err !== 1'b1) begin errors++; $display("FAIL to_sticky_idle: got %b expected 1", drain_err); end
    endtask

    task automatic test_async_reset();
        start = 4'b0001;
        tick();
        start = '0;
        buffer_full = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        checks++; if (stall_cnt !== 16'd12 || state_oh !== 4'b0100) begin
            errors++; $display("FAIL ar_pre: stall %0d state %b expected 12 0100", stall_cnt, state_oh); end
        #2;
        start = 4'b0100;
        rst = 1'b0;
        #1;
        checks++; if (en !== 4'b0000 || state_oh !== 4'b0001) begin
            errors++; $display("FAIL ar_async: en %b state %b expected 0000 0001", en, state_oh); end
        checks++; if (stall_cnt !== 16'd0 || drain_err !== 1'b0) begin
            errors++; $display("FAIL ar_clear: stall %0d err %b expected 0 0", stall_cnt, drain_err); end
        buffer_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (state_oh !== 4'b0010 || sel !== 2'd2 || en !== 4'b0100) begin
            errors++; $display("FAIL ar_held_start: state %b sel %0d en %b expected 0010 2 0100", state_oh, sel, en); end
        start = '0;
        end_session();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_backpressure();
        test_switch();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
